// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// Optional three-sample majority vote is enabled with UART_RX_MAJORITY_VOTE_EN.
package uart_rx_pkg;

  localparam int unsigned PRESCALE_W     = 5;
  localparam int unsigned BIT_CNT_W      = 4;
  localparam int unsigned START_IDX      = 0;
  localparam int unsigned DATA_FIRST_IDX = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // 2-of-3 vote used by the oversampling sampler
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Serial line, configuration, edge/bit counter and result signals of the receiver.
import uart_rx_pkg::*;

interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESCALE_W-1:0] edge_count;
  logic [BIT_CNT_W-1:0]  bit_count;
  logic                  edge_end;
  logic                  cnt_en;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_valid;
  logic                  Par_err;
  logic                  Stp_err;

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP, edge_count, bit_count, edge_end,
    output cnt_en, P_DATA, Data_valid, Par_err, Stp_err
  );

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP, edge_count, bit_count, edge_end,
    input  cnt_en, P_DATA, Data_valid, Par_err, Stp_err
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Mid-bit sampler; with UART_RX_MAJORITY_VOTE_EN it votes over ticks P/2-1, P/2, P/2+1,
// otherwise it takes the single sample at tick P/2.
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_count,
  input  logic                  enable,
  output logic                  bit_val
);

  logic [PRESCALE_W-1:0] mid_tick;
  assign mid_tick = prescale >> 1;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [PRESCALE_W-1:0] early_tick;
  logic [PRESCALE_W-1:0] late_tick;
  logic                  s_early;
  logic                  s_mid;

  assign early_tick = mid_tick - PRESCALE_W'(1);
  assign late_tick  = mid_tick + PRESCALE_W'(1);

  // Third sample is voted live so the result settles by tick P/2+2 (<= P for P >= 6)
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      s_early <= 1'b0;
      s_mid   <= 1'b0;
      bit_val <= 1'b0;
    end else if (enable) begin
      if (edge_count == early_tick) s_early <= rx_in;
      if (edge_count == mid_tick)   s_mid   <= rx_in;
      if (edge_count == late_tick)  bit_val <= majority3(s_early, s_mid, rx_in);
    end
  end
`else
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      bit_val <= 1'b0;
    end else if (enable && (edge_count == mid_tick)) begin
      bit_val <= rx_in;
    end
  end
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, LSB-first data shift, parity and stop checks.
// Sampling mode selected by UART_RX_MAJORITY_VOTE_EN (see uart_rx_sampler).
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic            CLK,
  input  logic            Reset,
  uart_rx_ctrl_if.slave   bus
);

  localparam logic [BIT_CNT_W-1:0] START_BIT = BIT_CNT_W'(START_IDX);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_FIRST_IDX + DATA_WIDTH - 1);

  rx_state_t             state_q, state_nxt;
  logic                  cnt_en_q, cnt_en_nxt;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_nxt;
  logic                  dv_q, dv_nxt;
  logic                  pe_q, pe_nxt;
  logic                  se_q, se_nxt;
  logic                  par_en_q, par_en_nxt;
  logic                  par_typ_q, par_typ_nxt;
  logic                  par_fail_q, par_fail_nxt;
  logic                  voted;

  uart_rx_sampler u_sampler (
    .CLK        (CLK),
    .Reset      (Reset),
    .rx_in      (bus.RX_IN),
    .prescale   (bus.Prescale),
    .edge_count (bus.edge_count),
    .enable     (cnt_en_q),
    .bit_val    (voted)
  );

  // State and registered outputs
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cnt_en_q   <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_fail_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cnt_en_q   <= cnt_en_nxt;
      p_data_q   <= p_data_nxt;
      dv_q       <= dv_nxt;
      pe_q       <= pe_nxt;
      se_q       <= se_nxt;
      par_en_q   <= par_en_nxt;
      par_typ_q  <= par_typ_nxt;
      par_fail_q <= par_fail_nxt;
    end
  end

  // Next-state logic; every bit decision is taken on the bit's last tick
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:   if (!bus.RX_IN) state_nxt = START;
      START:  if (bus.edge_end && (bus.bit_count == START_BIT))
                state_nxt = voted ? IDLE : DATA;
      DATA:   if (bus.edge_end && (bus.bit_count == LAST_DATA))
                state_nxt = par_en_q ? PARITY : STOP;
      PARITY: if (bus.edge_end) state_nxt = STOP;
      STOP:   if (bus.edge_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    cnt_en_nxt   = (state_nxt != IDLE);
    p_data_nxt   = p_data_q;
    dv_nxt       = 1'b0;
    pe_nxt       = 1'b0;
    se_nxt       = 1'b0;
    par_en_nxt   = par_en_q;
    par_typ_nxt  = par_typ_q;
    par_fail_nxt = par_fail_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.RX_IN) begin
          par_en_nxt   = bus.PAR_EN;
          par_typ_nxt  = bus.PAR_TYP;
          par_fail_nxt = 1'b0;
        end
      end
      DATA: begin
        if (bus.edge_end) p_data_nxt = {voted, p_data_q[DATA_WIDTH-1:1]};
      end
      PARITY: begin
        if (bus.edge_end && (voted != (^p_data_q ^ par_typ_q))) begin
          pe_nxt       = 1'b1;
          par_fail_nxt = 1'b1;
        end
      end
      STOP: begin
        if (bus.edge_end) begin
          if (!voted)           se_nxt = 1'b1;
          else if (!par_fail_q) dv_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.cnt_en     = cnt_en_q;
  assign bus.P_DATA     = p_data_q;
  assign bus.Data_valid = dv_q;
  assign bus.Par_err    = pe_q;
  assign bus.Stp_err    = se_q;

endmodule
